mem_access_unit: RTL

Request/response front end for `mainMemory` port A. It sits between the pipeline memory stage and `mainMemory`, and turns a valid/ready request into one correctly timed access. It drives `modeSel`, `address_a`, `data_a` and `wren` from registers and absorbs the port-A read latency. Each load or store returns exactly one response, held until the consumer accepts it.

---
 rtl/mem_access_pkg.sv | 17 +
 rtl/mem_access_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and sizes for the mainMemory port-A request/response front end.
package mem_access_pkg;

  localparam int LANES             = 6;
  localparam int LANE_W            = 12;
  localparam int VEC_W             = 72;
  localparam int ADDR_W            = 19;
  localparam int MEM_WORDS_DEFAULT = 393216;  // 6 segments x 65536 words

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Turns one valid/ready request into a single timed port-A access of mainMemory,
// absorbs the read latency and holds exactly one response until it is accepted.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS    = MEM_WORDS_DEFAULT,
  parameter int READ_LATENCY = 1                   // legal 1..3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_vector,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [VEC_W-1:0]  rsp_rdata,
  output logic              rsp_error,
  output logic              mem_modeSel,
  output logic [ADDR_W-1:0] mem_address_a,
  output logic [VEC_W-1:0]  mem_data_a,
  output logic              mem_wren,
  input  logic [VEC_W-1:0]  mem_q_a
);

  // One extra bit so that addr + (LANES-1) can never wrap.
  localparam int                SUM_W     = ADDR_W + 1;
  localparam logic [SUM_W-1:0]  MEM_LIMIT = SUM_W'(MEM_WORDS);
  localparam logic [1:0]        LAT_INIT  = 2'(READ_LATENCY - 1);

  state_t             state;
  state_t             state_next;
  logic [1:0]         lat_cnt;
  logic               cap_write;
  logic [SUM_W-1:0]   last_word;
  logic               in_range;
  logic               accept;
  logic               capture;

  // Address of the last word the request would touch, checked against the array size.
  always_comb begin
    last_word = {1'b0, req_addr} + (req_vector ? SUM_W'(LANES - 1) : '0);
    in_range  = (last_word < MEM_LIMIT);
  end

  // Next-state decode and handshake strobes.
  // NOTE: every output of this block gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = in_range ? ISSUE : RESP;
        end
      end
      ISSUE: state_next = cap_write ? RESP : WAIT;
      WAIT: begin
        if (lat_cnt == 2'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Port-A drive registers: loaded only for an in-range accept, held until the next one.
  // The write strobe is set for exactly the ISSUE cycle of a store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wren      <= 1'b0;
      mem_modeSel   <= 1'b0;
      mem_address_a <= '0;
      mem_data_a    <= '0;
      cap_write     <= 1'b0;
    end else begin
      mem_wren <= accept && in_range && req_write;
      if (accept) begin
        cap_write <= req_write;
        if (in_range) begin
          mem_modeSel   <= req_vector;
          mem_address_a <= req_addr;
          mem_data_a    <= req_wdata;
        end
      end
    end
  end

  // Read-latency counter: armed in ISSUE, counted down while waiting for mem_q_a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= 2'd0;
    end else if (state == ISSUE) begin
      lat_cnt <= LAT_INIT;
    end else if ((state == WAIT) && (lat_cnt != 2'd0)) begin
      lat_cnt <= lat_cnt - 2'd1;
    end
  end

  // Response register: cleared on accept (stores and errors return zero data),
  // filled from mem_q_a when the load data is due; scalar loads keep lane 0 only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= '0;
      rsp_error <= !in_range;
    end else if (capture) begin
      rsp_rdata <= mem_modeSel ? mem_q_a
                               : {{(VEC_W - LANE_W){1'b0}}, mem_q_a[LANE_W-1:0]};
    end
  end

endmodule
